// File: rtl/mcs_io_bus_master.sv
// mcs_io_bus_master: UART-driven initiator for the MCS IO bus.
// Parses 'W'/'R' command frames from a received byte stream, issues one
// 32-bit bus access per frame and answers with read data or a status byte.
// Optional feature macro: MCS_BUS_MASTER_TIMEOUT_EN (bounded wait for io_ready).
module mcs_io_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  OP_WR          = 8'h57,
    parameter logic [7:0]  OP_RD          = 8'h52
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_address,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_ISSUE,
        S_WAIT_RDY,
        S_SEND
    } state_e;

    state_e      state_q, state_d;
    logic        is_wr_q, is_wr_d;        // direction latched from the opcode
    logic [1:0]  byte_cnt_q, byte_cnt_d;  // position within address/data field
    logic [23:0] frame_sh_q, frame_sh_d;  // three most recent field bytes
    logic [31:0] io_addr_q, io_addr_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_err_q, resp_err_d;  // reply is 'E' after a timeout
    logic [1:0]  tx_idx_q, tx_idx_d;      // reply byte being sent
    logic        tx_guard_q, tx_guard_d;  // cycle after tx_start, busy not sampled
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        rx_drop;
    logic        timeout_hit;
    logic [1:0]  tx_last;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;

    // The 16-bit wait counter must be able to reach TIMEOUT_CYCLES.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout_cfg
        $error("mcs_io_bus_master: TIMEOUT_CYCLES out of range");
    end

`ifdef MCS_BUS_MASTER_TIMEOUT_EN
    logic [15:0] tmo_q;

    // Wait counter: cleared while strobing, counts every cycle spent in WAIT_RDY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (state_q == S_ISSUE) begin
            tmo_q <= '0;
        end else if (state_q == S_WAIT_RDY) begin
            tmo_q <= tmo_q + 16'd1;
        end
    end

    // A ready pulse in the cycle the limit is reached takes precedence.
    assign timeout_hit = (state_q == S_WAIT_RDY) && !io_ready &&
                         (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Writes and timeouts answer with one byte, reads with four.
    assign tx_last = (is_wr_q || resp_err_q) ? 2'd0 : 2'd3;

    // Next-state and output decode for the frame/access/reply sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d         = state_q;
        is_wr_d         = is_wr_q;
        byte_cnt_d      = byte_cnt_q;
        frame_sh_d      = frame_sh_q;
        io_addr_d       = io_addr_q;
        io_wdata_d      = io_wdata_q;
        rdata_d         = rdata_q;
        resp_err_d      = resp_err_q;
        tx_idx_d        = tx_idx_q;
        tx_guard_d      = tx_guard_q;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_enable  = 4'b0000;
        tx_start        = 1'b0;
        tx_data         = 8'h00;
        rx_drop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Anything that is not an opcode is discarded without counting.
                if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) begin
                    is_wr_d    = (rx_data == OP_WR);
                    byte_cnt_d = 2'd0;
                    state_d    = S_GET_ADDR;
                end
            end

            S_GET_ADDR: begin
                if (rx_valid) begin
                    frame_sh_d = {frame_sh_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        io_addr_d = {frame_sh_q, rx_data};
                        state_d   = is_wr_q ? S_GET_DATA : S_ISSUE;
                    end
                end
            end

            S_GET_DATA: begin
                if (rx_valid) begin
                    frame_sh_d = {frame_sh_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        io_wdata_d = {frame_sh_q, rx_data};
                        state_d    = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                io_addr_strobe  = 1'b1;
                io_read_strobe  = !is_wr_q;
                io_write_strobe = is_wr_q;
                io_byte_enable  = 4'b1111;
                rx_drop         = rx_valid;
                resp_err_d      = 1'b0;
                tx_idx_d        = 2'd0;
                tx_guard_d      = 1'b0;
                state_d         = S_WAIT_RDY;
            end

            S_WAIT_RDY: begin
                rx_drop = rx_valid;
                if (io_ready) begin
                    if (!is_wr_q) begin
                        rdata_d = io_read_data;
                    end
                    state_d = S_SEND;
                end else if (timeout_hit) begin
                    resp_err_d = 1'b1;
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                rx_drop = rx_valid;
                if (tx_guard_q) begin
                    // Transmitter may not have raised tx_busy yet; skip this cycle.
                    tx_guard_d = 1'b0;
                    if (tx_idx_q == tx_last) begin
                        state_d = S_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 2'd1;
                    end
                end else if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_guard_d = 1'b1;
                    if (resp_err_q) begin
                        tx_data = RESP_ERR;
                    end else if (is_wr_q) begin
                        tx_data = RESP_OK;
                    end else begin
                        case (tx_idx_q)
                            2'd0:    tx_data = rdata_q[31:24];
                            2'd1:    tx_data = rdata_q[23:16];
                            2'd2:    tx_data = rdata_q[15:8];
                            default: tx_data = rdata_q[7:0];
                        endcase
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating error counter; a drop and a timeout in one cycle add two.
    always_comb begin
        err_inc   = {1'b0, rx_drop} + {1'b0, timeout_hit};
        err_sum   = {1'b0, err_cnt_q} + {7'b0, err_inc};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            byte_cnt_q <= 2'd0;
            resp_err_q <= 1'b0;
            tx_idx_q   <= 2'd0;
            tx_guard_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            byte_cnt_q <= byte_cnt_d;
            resp_err_q <= resp_err_d;
            tx_idx_q   <= tx_idx_d;
            tx_guard_q <= tx_guard_d;
        end
    end

    // Datapath registers: frame shifter, bus address/data, read capture, errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_sh_q <= '0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            rdata_q    <= '0;
            err_cnt_q  <= '0;
        end else begin
            frame_sh_q <= frame_sh_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            rdata_q    <= rdata_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign io_address    = io_addr_q;
    assign io_write_data = io_wdata_q;
    assign busy          = (state_q != S_IDLE);
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_mcs_io_bus_master.sv
// tb_mcs_io_bus_master: scoreboard bench for mcs_io_bus_master.
// Bus accesses and reply bytes are queued when a frame is driven and
// checked by a bus responder and a UART transmitter model.
// Optional feature macro: MCS_BUS_MASTER_TIMEOUT_EN (adds timeout scenarios).
module tb_mcs_io_bus_master;

`ifdef MCS_BUS_MASTER_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1024;
`endif

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          no_ready;
    } bus_txn_t;

    typedef enum {RESP_NORMAL, RESP_ERR, RESP_NONE} resp_e;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        busy;
    logic [7:0]  err_cnt;

    bus_txn_t    bus_q[$];
    logic [7:0]  tx_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          busy_left = 0;
    int          exp_err = 0;

    mcs_io_bus_master #(
        .TIMEOUT_CYCLES (TMO),
        .OP_WR          (8'h57),
        .OP_RD          (8'h52)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .tx_busy         (tx_busy),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .busy            (busy),
        .err_cnt         (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART transmitter model: checks each tx_start against the reply queue,
    // then stays busy for a few cycles (or as long as a test presets).
    initial begin : tx_model
        logic [7:0] exp_b;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                n_tests++;
                if (tx_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tx_start_while_busy: tx_busy=%b required 0", tx_busy);
                end
                n_tests++;
                if (tx_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: tx_data=%h with no reply byte expected", tx_data);
                end else begin
                    exp_b = tx_q.pop_front();
                    if (tx_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %h required %h", tx_data, exp_b);
                    end
                end
                busy_left = 3;
            end
            @(posedge clk);
            #1;
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    // Bus responder: checks each strobe against the access queue and answers
    // with io_ready after the queued delay (counted from the strobe cycle).
    initial begin : bus_model
        bus_txn_t t;
        io_ready     = 1'b0;
        io_read_data = '0;
        forever begin
            @(negedge clk);
            if (io_addr_strobe === 1'b1) begin
                n_tests++;
                if (bus_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_unexpected: strobe with addr=%h", io_address);
                end else begin
                    t = bus_q.pop_front();
                    if ({io_read_strobe, io_write_strobe, io_byte_enable} !== {~t.is_wr, t.is_wr, 4'hF} ||
                        io_address !== t.addr || (t.is_wr && io_write_data !== t.wdata)) begin
                        n_fail++;
                        $display("FAIL bus_access: rd=%b wr=%b be=%h addr=%h wdata=%h required rd=%b wr=%b be=f addr=%h wdata=%h",
                                 io_read_strobe, io_write_strobe, io_byte_enable, io_address, io_write_data,
                                 ~t.is_wr, t.is_wr, t.addr, t.wdata);
                    end
                    @(negedge clk);
                    n_tests++;
                    if ({io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable} !== 7'b0 ||
                        io_address !== t.addr) begin
                        n_fail++;
                        $display("FAIL strobe_width: strobes=%b be=%h addr=%h required 000 0 %h",
                                 {io_addr_strobe, io_read_strobe, io_write_strobe}, io_byte_enable,
                                 io_address, t.addr);
                    end
                    if (!t.no_ready) begin
                        repeat (t.delay - 1) @(posedge clk);
                        #1;
                        io_ready     = 1'b1;
                        io_read_data = t.rdata;
                        @(negedge clk);
                        n_tests++;
                        if (tx_start !== 1'b0) begin
                            n_fail++;
                            $display("FAIL tx_before_ready: tx_start=%b required 0", tx_start);
                        end
                        @(posedge clk);
                        #1;
                        io_ready     = 1'b0;
                        io_read_data = $urandom;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 1)) @(posedge clk);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Queue expectations for one frame, drive it, and check the strobe lands
    // in the cycle right after the final byte.
    task automatic issue(input logic is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay, input resp_e resp);
        bus_txn_t t;
        t.is_wr    = is_wr;
        t.addr     = addr;
        t.wdata    = wdata;
        t.rdata    = rdata;
        t.delay    = delay;
        t.no_ready = (resp != RESP_NORMAL);
        bus_q.push_back(t);
        if (resp == RESP_ERR) begin
            tx_q.push_back(8'h45);
        end else if (resp == RESP_NORMAL) begin
            if (is_wr) begin
                tx_q.push_back(8'h4B);
            end else begin
                for (int i = 3; i >= 0; i--) tx_q.push_back(rdata[i*8 +: 8]);
            end
        end
        send_byte(is_wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
        if (is_wr) begin
            for (int i = 3; i >= 0; i--) send_byte(wdata[i*8 +: 8]);
        end
        @(negedge clk);
        n_tests++;
        if (io_addr_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_timing: io_addr_strobe=%b required 1 after last byte", io_addr_strobe);
        end
    endtask

    // Bounded wait for the DUT to return to IDLE with both queues drained.
    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tx_q.size() == 0 && bus_q.size() == 0) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b tx_left=%0d bus_left=%0d required idle, empty",
                     busy, tx_q.size(), bus_q.size());
        end
    endtask

    task automatic check_err(input string name);
        n_tests++;
        if (err_cnt !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL %s: err_cnt=%0d required %0d", name, err_cnt, exp_err);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable, tx_start,
             tx_data, io_address, io_write_data, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b strobes=%b be=%h tx=%b/%h addr=%h wdata=%h err=%h required all 0",
                     busy, {io_addr_strobe, io_read_strobe, io_write_strobe}, io_byte_enable,
                     tx_start, tx_data, io_address, io_write_data, err_cnt);
        end
        reset_n = 1'b1;
        exp_err = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        issue(1'b1, 32'hC000_0010, 32'h0000_00FF, 32'h0, 3, RESP_NORMAL);
        wait_idle(200);
        check_err("write_err_cnt");
        n_tests++;
        if (io_address !== 32'hC000_0010 || io_write_data !== 32'h0000_00FF || io_byte_enable !== 4'h0) begin
            n_fail++;
            $display("FAIL write_hold: addr=%h wdata=%h be=%h required c0000010 000000ff 0",
                     io_address, io_write_data, io_byte_enable);
        end
    endtask

    task automatic test_read();
        busy_left = 25;
        issue(1'b0, 32'hC000_0400, 32'h0, 32'h1234_5678, 4, RESP_NORMAL);
        wait_idle(300);
        check_err("read_err_cnt");
    endtask

    task automatic test_ignore();
        send_byte(8'h41);
        @(posedge clk);
        #1;
        io_ready = 1'b1;
        @(posedge clk);
        #1;
        io_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy: busy=%b required 0", busy);
        end
        check_err("ignore_err_cnt");
        issue(1'b0, 32'hC000_0400, 32'h0, 32'hA5A5_0F0F, 2, RESP_NORMAL);
        wait_idle(200);
    endtask

    task automatic test_drop();
        issue(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 6, RESP_NORMAL);
        send_byte(8'h57);
        exp_err++;
        wait_idle(200);
        check_err("drop_err_cnt");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            issue(1'(i), $urandom, $urandom, $urandom, int'($urandom_range(2, 6)), RESP_NORMAL);
            wait_idle(200);
        end
        check_err("b2b_err_cnt");
    endtask

`ifdef MCS_BUS_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        issue(1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, RESP_ERR);
        exp_err++;
        wait_idle(200);
        check_err("timeout_err_cnt");
        issue(1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, int'(TMO), RESP_NORMAL);
        wait_idle(200);
        check_err("ready_at_limit_err_cnt");
    endtask
`endif

    // Reply held back by a busy transmitter; bytes arriving in SEND are dropped
    // until the counter pins at 255.
    task automatic test_err_saturate();
        busy_left = 2000;
        issue(1'b0, 32'h0000_0100, 32'h0, 32'h0102_0304, 2, RESP_NORMAL);
        repeat (8) @(posedge clk);
        for (int i = 0; i < 260; i++) send_byte(8'h00);
        exp_err = 255;
        @(negedge clk);
        check_err("err_saturate");
        wait_idle(3000);
        check_err("err_saturate_hold");
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h0000_0200, 32'h0, 32'h0, 0, RESP_NONE);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable, tx_start,
             tx_data, io_address, io_write_data, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b be=%h tx=%b addr=%h wdata=%h err=%h required all 0",
                     busy, io_byte_enable, tx_start, io_address, io_write_data, err_cnt);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_err = 0;
        repeat (20) @(negedge clk);
        issue(1'b1, 32'hC000_0020, 32'h1357_9BDF, 32'h0, 3, RESP_NORMAL);
        wait_idle(200);
        check_err("reset_mid_err_cnt");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore();
        test_drop();
        test_back_to_back();
`ifdef MCS_BUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_err_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
